// File: rtl/uncache_bridge_pkg.sv
// ----------------------------------------------------------------------------
// uncache_bridge_pkg
// Shared definitions for the uncached-access bridge:
//   state_t   - bridge FSM states (IDLE, REQ, WAIT, DONE)
//   SIZE_*    - transfer size codes used on cpu_size / bus_size
// ----------------------------------------------------------------------------
package uncache_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/uncache_addr_align.sv
// ----------------------------------------------------------------------------
// uncache_addr_align
// Purely combinational address alignment for the outgoing bus request.
// Word transfers force addr[1:0]=00, halfword transfers force addr[0]=0,
// byte transfers pass the address through unchanged.
// Ports:
//   size     in  2   transfer size code (SIZE_BYTE/SIZE_HALF/SIZE_WORD)
//   addr     in  32  latched request address
//   aligned  out 32  address presented on the bus
// ----------------------------------------------------------------------------
module uncache_addr_align
    import uncache_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic [31:0] aligned
);

    always_comb begin
        aligned = addr;
        if (size == SIZE_WORD) begin
            aligned[1:0] = 2'b00;
        end else if (size == SIZE_HALF) begin
            aligned[0] = 1'b0;
        end
    end

endmodule

// File: rtl/uncache_bridge.sv
// ----------------------------------------------------------------------------
// uncache_bridge
// Converts a CPU uncached data access (cpu_en & no_dcache) into a single
// SRAM-like bus transaction (req/addr_ok/data_ok handshake). One transaction
// is outstanding at a time; the CPU is stalled until it completes.
//
// Optional feature (macro UNCACHE_WBUF_EN): one-entry posted write buffer.
// A store seen in IDLE is accepted without stalling and drained on the bus in
// the background; any uncached access arriving meanwhile stalls until the
// store's data_ok and then runs its own transaction.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_en, no_dcache        CPU request valid / request is uncached
//   cpu_wen[3:0]             byte write enables (0 = read)
//   cpu_size[1:0]            0=byte, 1=half, 2=word
//   cpu_addr[31:0]           physical address
//   cpu_wdata[31:0]          store data
//   cpu_rdata[31:0]          load data (holds until next read completes)
//   cpu_stall                hold CPU pipeline
//   bus_req, bus_wr          bus request / write flag
//   bus_size, bus_addr       transfer size / aligned address
//   bus_wdata                write data
//   bus_addr_ok, bus_data_ok request accepted / transfer complete
//   bus_rdata[31:0]          read data, valid with bus_data_ok
// ----------------------------------------------------------------------------
module uncache_bridge
    import uncache_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        no_dcache,
    input  logic [3:0]  cpu_wen,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    state_t      state_reg, state_next;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;

    logic        req_active;
    logic        latch_req;
    logic        capture_rdata;
    logic        post_now;     // request in IDLE may be posted (no stall)
    logic        posted_reg;   // current transaction is a posted store

    assign req_active = cpu_en & no_dcache;

`ifdef UNCACHE_WBUF_EN
    logic posted_next;

    // Any store found in IDLE can be posted: the buffer is always empty
    // there, because a posted store only returns to IDLE after its data_ok.
    assign post_now = |cpu_wen;

    // posted_reg stays set through DONE so that a request which arrived
    // while the store drained is not released before its own transaction.
    always_comb begin
        posted_next = posted_reg;
        if (state_reg == IDLE && req_active) begin
            posted_next = post_now;
        end else if (state_reg == DONE) begin
            posted_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            posted_reg <= 1'b0;
        end else begin
            posted_reg <= posted_next;
        end
    end
`else
    assign post_now   = 1'b0;
    assign posted_reg = 1'b0;
`endif

    // Next-state and stall logic
    always_comb begin
        state_next = state_reg;
        latch_req  = 1'b0;
        cpu_stall  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_active) begin
                    state_next = REQ;
                    latch_req  = 1'b1;
                    cpu_stall  = ~post_now;
                end
            end
            REQ: begin
                // While a posted store drains, only a new uncached request stalls.
                cpu_stall = posted_reg ? req_active : 1'b1;
                if (bus_addr_ok) begin
                    state_next = bus_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                cpu_stall = posted_reg ? req_active : 1'b1;
                if (bus_data_ok) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A request waiting behind a posted store has not been served yet.
                cpu_stall  = posted_reg & req_active;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // data_ok only counts once the request has been accepted
    assign capture_rdata = ~wr_reg & bus_data_ok &
                           (((state_reg == REQ) & bus_addr_ok) | (state_reg == WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wr_reg    <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (latch_req) begin
                wr_reg    <= |cpu_wen;
                size_reg  <= cpu_size;
                addr_reg  <= cpu_addr;
                wdata_reg <= cpu_wdata;
            end
            if (capture_rdata) begin
                rdata_reg <= bus_rdata;
            end
        end
    end

    uncache_addr_align u_align (
        .size    (size_reg),
        .addr    (addr_reg),
        .aligned (bus_addr)
    );

    assign bus_req   = (state_reg == REQ);
    assign bus_wr    = wr_reg;
    assign bus_size  = size_reg;
    assign bus_wdata = wdata_reg;
    assign cpu_rdata = rdata_reg;

endmodule

// File: tb/tb_uncache_bridge.sv
// ----------------------------------------------------------------------------
// tb_uncache_bridge
// Scoreboard bench: each CPU access pushes its expected bus fields (and, for
// reads, the expected load data); a bus responder pops and compares when the
// bridge's request is accepted, and the CPU side pops and compares load data
// when the stall releases. Honours UNCACHE_WBUF_EN for store-stall timing.
// ----------------------------------------------------------------------------
module tb_uncache_bridge;
    import uncache_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en, no_dcache;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    uncache_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .no_dcache   (no_dcache),
        .cpu_wen     (cpu_wen),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];

    // responder controls
    bit          resp_en   = 1'b1;
    bit          stray_en  = 1'b0;
    int          addr_lat  = 0;
    int          data_lat  = 0;
    int          req_wait  = 0;
    int          dcnt      = 0;
    bit          pending   = 1'b0;
    logic [31:0] cur_rdata = 32'h0;
    int          last_req_len = 0;

    // Bus responder: samples and drives on the falling edge.
    initial begin : responder
        bus_exp_t e;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                bus_addr_ok = 1'b0;
                bus_data_ok = 1'b0;
                if (pending) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = cur_rdata;
                        pending     = 1'b0;
                    end
                end else if (bus_req) begin
                    if (req_wait == addr_lat) begin
                        bus_addr_ok  = 1'b1;
                        last_req_len = req_wait + 1;
                        req_wait     = 0;
                        if (bus_q.size() == 0) begin
                            check_val("bus_unexpected_req", 32'd1, 32'd0);
                        end else begin
                            e = bus_q.pop_front();
                            check_val("bus_wr",   {31'd0, bus_wr},   {31'd0, e.wr});
                            check_val("bus_size", {30'd0, bus_size}, {30'd0, e.size});
                            check_val("bus_addr", bus_addr, e.addr);
                            if (e.wr) check_val("bus_wdata", bus_wdata, e.wdata);
                            if (data_lat == 0) begin
                                bus_data_ok = 1'b1;
                                bus_rdata   = e.rdata;
                            end else begin
                                pending   = 1'b1;
                                dcnt      = data_lat;
                                cur_rdata = e.rdata;
                            end
                        end
                    end else begin
                        req_wait++;
                        if (stray_en) begin
                            bus_data_ok = 1'b1;
                            bus_rdata   = 32'hBAD0_BAD0;
                        end
                    end
                end
            end
        end
    end

    // One CPU access; starts just after a rising edge, ends just after one.
    task automatic cpu_op(input string tag, input logic [3:0] wen, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input int exp_stall);
        bus_exp_t    e;
        int          stalls;
        bit          done;
        logic [31:0] r;
        e.wr    = |wen;
        e.size  = size;
        e.addr  = exp_addr;
        e.wdata = wdata;
        e.rdata = rdata;
        bus_q.push_back(e);
        if (wen == 4'b0) rd_q.push_back(rdata);
        cpu_en    = 1'b1;
        no_dcache = 1'b1;
        cpu_wen   = wen;
        cpu_size  = size;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (cpu_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        check_val({tag, "_stall"}, stalls, exp_stall);
        if (wen == 4'b0 && done) begin
            r = rd_q.pop_front();
            check_val({tag, "_rdata"}, cpu_rdata, r);
        end
        $display("txn %s wen=%h size=%0d addr=%h stall_cycles=%0d rdata=%h",
                 tag, wen, size, addr, stalls, cpu_rdata);
        @(posedge clk);
        #1;
        cpu_en  = 1'b0;
        cpu_wen = 4'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst         = 1'b1;
        cpu_en      = 1'b0;
        no_dcache   = 1'b0;
        cpu_wen     = 4'b0;
        cpu_size    = 2'b0;
        cpu_addr    = 32'h0;
        cpu_wdata   = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_bus_req", {31'd0, bus_req},   32'd0);
        check_val("rst_stall",   {31'd0, cpu_stall}, 32'd0);
        check_val("rst_rdata",   cpu_rdata, 32'h0);
        check_val("rst_bus_addr", bus_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // word read, addr_ok first cycle, data_ok two cycles later
        addr_lat = 0; data_lat = 2;
        cpu_op("rd_word", 4'b0, SIZE_WORD, 32'h1FAF_F004, 32'h0, 32'hDEAD_BEEF, 32'h1FAF_F004, 4);
        check_val("rd_word_reqlen", last_req_len, 32'd1);

        // same-cycle addr_ok & data_ok
        addr_lat = 0; data_lat = 0;
        cpu_op("rd_fast", 4'b0, SIZE_WORD, 32'h1FAF_F008, 32'h0, 32'h1234_5678, 32'h1FAF_F008, 2);
        check_val("rd_fast_reqlen", last_req_len, 32'd1);

        // byte store then half read back-to-back; store rdata is junk and must be ignored
        addr_lat = 0; data_lat = 1;
`ifdef UNCACHE_WBUF_EN
        cpu_op("st_byte", 4'b0010, SIZE_BYTE, 32'h1FAF_F0F1, 32'h0000_AB00, 32'hFFFF_FFFF, 32'h1FAF_F0F1, 0);
        check_val("rdata_hold_st", cpu_rdata, 32'h1234_5678);
        cpu_op("rd_half", 4'b0, SIZE_HALF, 32'h1FAF_F0F3, 32'h0, 32'h0000_CAFE, 32'h1FAF_F0F2, 6);
`else
        cpu_op("st_byte", 4'b0010, SIZE_BYTE, 32'h1FAF_F0F1, 32'h0000_AB00, 32'hFFFF_FFFF, 32'h1FAF_F0F1, 3);
        check_val("rdata_hold_st", cpu_rdata, 32'h1234_5678);
        cpu_op("rd_half", 4'b0, SIZE_HALF, 32'h1FAF_F0F3, 32'h0, 32'h0000_CAFE, 32'h1FAF_F0F2, 3);
`endif

        // word store; load data must hold afterwards
`ifdef UNCACHE_WBUF_EN
        cpu_op("st_word", 4'b1111, SIZE_WORD, 32'h8000_0010, 32'hA5A5_5A5A, 32'h0BAD_F00D, 32'h8000_0010, 0);
`else
        cpu_op("st_word", 4'b1111, SIZE_WORD, 32'h8000_0010, 32'hA5A5_5A5A, 32'h0BAD_F00D, 32'h8000_0010, 3);
`endif
        repeat (6) @(negedge clk);
        check_val("rdata_hold_idle", cpu_rdata, 32'h0000_CAFE);
        @(posedge clk);
        #1;

        // unaligned word read with delayed addr_ok and stray data_ok before acceptance
        addr_lat = 2; data_lat = 1; stray_en = 1'b1;
        cpu_op("rd_unal", 4'b0, SIZE_WORD, 32'h8000_0007, 32'h0, 32'h0F0F_F0F0, 32'h8000_0004, 5);
        check_val("rd_unal_reqlen", last_req_len, 32'd3);
        stray_en = 1'b0;

        // cached access is ignored
        cpu_en = 1'b1; no_dcache = 1'b0; cpu_wen = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("cached_bus_req", {31'd0, bus_req},   32'd0);
            check_val("cached_stall",   {31'd0, cpu_stall}, 32'd0);
        end
        @(posedge clk);
        #1 cpu_en = 1'b0; cpu_wen = 4'b0;

        // reset in WAIT, then a stray data_ok
        resp_en = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        cpu_en = 1'b1; no_dcache = 1'b1; cpu_wen = 4'b0;
        cpu_size = SIZE_WORD; cpu_addr = 32'h1FAF_F010;
        @(negedge clk);
        check_val("rstw_idle_stall", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        check_val("rstw_req", {31'd0, bus_req}, 32'd1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        check_val("rstw_wait_req",   {31'd0, bus_req},   32'd0);
        check_val("rstw_wait_stall", {31'd0, cpu_stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rstw_bus_req",  {31'd0, bus_req},   32'd0);
        check_val("rstw_rdata",    cpu_rdata, 32'h0);
        check_val("rstw_bus_addr", bus_addr,  32'h0);
        check_val("rstw_stall_held", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0; cpu_en = 1'b0;
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
        check_val("rstw_post_req",   {31'd0, bus_req},   32'd0);
        check_val("rstw_post_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk);
        #1 bus_data_ok = 1'b0;
        @(negedge clk);
        check_val("rstw_stray_rdata", cpu_rdata, 32'h0);
        check_val("rstw_stray_req",   {31'd0, bus_req}, 32'd0);
        @(posedge clk);
        #1;
        resp_en = 1'b1; req_wait = 0; pending = 1'b0;

        // recovery read after reset
        addr_lat = 0; data_lat = 0;
        cpu_op("rd_recover", 4'b0, SIZE_BYTE, 32'h1FAF_F013, 32'h0, 32'h0000_0077, 32'h1FAF_F013, 2);

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", bus_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uncache_bridge.md
UNCACHE_BRIDGE -- requirements
Module: uncache_bridge

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  CPU data request valid, held until the cycle cpu_stall=0.
- no_dcache  in  1  request is uncached; the block acts only when cpu_en&no_dcache.
- cpu_wen  in  4  byte write enables; 0 = read.
- cpu_size  in  2  0=byte, 1=half, 2=word.
- cpu_addr  in  32  physical address (post-translation).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  hold CPU pipeline.
- bus_req  out  1  SRAM-like request.
- bus_wr  out  1  1=write.
- bus_size  out  2  transfer size.
- bus_addr  out  32  transfer address.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  transfer complete.
- bus_rdata  in  32  read data, valid with bus_data_ok.

Function
REQ-002 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-003 IDLE->REQ SHALL occur when cpu_en&no_dcache; the request fields (wr=|cpu_wen, size, addr, wdata) SHALL be latched.
REQ-004 In REQ, bus_req SHALL be 1 with the latched fields; REQ->WAIT on bus_addr_ok&~bus_data_ok; REQ->DONE on bus_addr_ok&bus_data_ok.
REQ-005 bus_data_ok in REQ without bus_addr_ok, or in IDLE/DONE, SHALL be ignored.
REQ-006 WAIT->DONE SHALL occur on bus_data_ok; bus_rdata SHALL be latched into cpu_rdata for reads.
REQ-007 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-008 cpu_stall SHALL be 1 when (cpu_en&no_dcache) in IDLE, and 1 in REQ or WAIT; it SHALL be 0 in DONE and whenever no uncached request is active.
REQ-009 For bus_size=2, bus_addr[1:0] SHALL be driven 00; for size 1, bus_addr[0] SHALL be 0; otherwise bus_addr SHALL equal the latched address.
REQ-010 cpu_rdata SHALL hold its last value until the next read completes.
REQ-011 bus_req SHALL be 0 in every state except REQ, and only one transaction SHALL be outstanding.

Reset
REQ-012 rst SHALL force IDLE immediately, including mid-transaction, with bus_req=0, cpu_rdata=0, cpu_stall=0 (absent a request), and all latched fields cleared to 0.
REQ-013 A bus_data_ok arriving after a mid-transaction reset SHALL be ignored.

Configuration
REQ-014 Macro UNCACHE_WBUF_EN SHALL compile in a one-entry posted write buffer.
REQ-015 With UNCACHE_WBUF_EN, a write in IDLE with an empty buffer SHALL be latched with cpu_stall=0 that cycle and drained through REQ/WAIT; any uncached request while the buffer is non-empty SHALL stall until the write's bus_data_ok; the buffer SHALL clear on that bus_data_ok.
REQ-016 Without UNCACHE_WBUF_EN, writes SHALL stall exactly like reads (REQ-008).

Structure
REQ-017 A shared package SHALL hold the FSM state enumeration and the size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD.
REQ-018 One combinational sub-module, uncache_addr_align, SHALL implement REQ-009; everything else SHALL reside in uncache_bridge.

Verification
REQ-019 Read: addr=0x1FAF_F004, size=2, addr_ok in cycle 1, data_ok=0xDEAD_BEEF in cycle 3 -> bus_req exactly 1 cycle, stall 1 for 4 cycles, cpu_rdata=0xDEADBEEF while stall=0.
REQ-020 Same-cycle addr_ok&data_ok with rdata 0x1234_5678 -> REQ->DONE directly, total stall 2 cycles.
REQ-021 Byte store wen=0010, addr=0x1FAF_F0F1 -> bus_wr=1, bus_size=0, bus_addr=0x1FAF_F0F1; half read at 0x...F0F3 -> bus_addr=0x...F0F2.
REQ-022 rst pulsed in WAIT, then stray data_ok -> bus_req=0, state IDLE, cpu_rdata=0, no stall release glitch.
REQ-023 no_dcache=0 with cpu_en=1 -> bus_req and cpu_stall stay 0.
REQ-024 UNCACHE_WBUF_EN: store then load back-to-back -> store stall=0, load stalls until the store's data_ok, then issues its own REQ.
